// File: rtl/tribus_arb_pkg.sv
// tribus_arb_pkg: shared state encoding, counter widths and parameter ranges for the tristate bus arbiter.
package tribus_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_OWN, S_TURN} state_e;
  localparam int HOLD_W = 8;
  localparam int PTR_W = 3;
  localparam int TURN_W = 3;
  localparam int N_REQ_MIN = 2;
  localparam int N_REQ_MAX = 8;
  localparam int TURN_CYC_MIN = 1;
  localparam int TURN_CYC_MAX = 7;
  localparam int MAX_HOLD_MIN = 2;
  localparam int MAX_HOLD_MAX = 255;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search from ptr_i upward with wrap-around; one-hot winner plus valid.
module rr_pick
  import tribus_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic             valid_o
);
  logic found;
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (!found && req_i[j] && j == (int'(ptr_i) + i) % N) begin
          gnt_o[j] = 1'b1;
          found = 1'b1;
        end
    valid_o = |req_i;
  end
endmodule

// File: rtl/tribus_arb.sv
// tribus_arb: grants one tristate driver at a time with round-robin fairness,
// a MAX_HOLD preemption timeout and TURN_CYC dead cycles between owners.
module tribus_arb
  import tribus_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_REQ-1:0] REQ,
  output logic [N_REQ-1:0] ENB,
  output logic [N_REQ-1:0] GNT,
  output logic             BUS_IDLE,
  output logic             PREEMPT
);
  state_e state_q, state_d;
  logic [N_REQ-1:0] enb_q, enb_d, pick;
  logic [PTR_W-1:0] ptr_q, ptr_d, pick_idx, nxt_ptr;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TURN_W-1:0] turn_q, turn_d;
  logic pre_q, pre_d, pick_v, own_req, others, arb, hold_max;

  rr_pick #(.N(N_REQ)) u_pick (.req_i(REQ), .ptr_i(ptr_q), .gnt_o(pick), .valid_o(pick_v));

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (pick[i]) pick_idx = PTR_W'(i);
    nxt_ptr = (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
  end

  // enb_q is one-hot on the owner while in OWN, so it doubles as the owner mask
  assign own_req  = |(REQ & enb_q);
  assign others   = |(REQ & ~enb_q);
  assign hold_max = hold_q == HOLD_W'(MAX_HOLD);
  assign arb      = state_q == S_IDLE || (state_q == S_TURN && turn_q == TURN_W'(TURN_CYC));

  always_comb begin
    state_d = state_q;
    enb_d   = enb_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    pre_d   = 1'b0;
    if (arb) begin
      state_d = pick_v ? S_OWN : S_IDLE;
      enb_d   = pick;
      hold_d  = pick_v ? HOLD_W'(1) : '0;
      ptr_d   = pick_v ? nxt_ptr : ptr_q;
    end else if (state_q == S_TURN) begin
      turn_d = turn_q + TURN_W'(1);
    end else if (!own_req || (hold_max && others)) begin
      state_d = S_TURN;
      enb_d   = '0;
      hold_d  = '0;
      turn_d  = TURN_W'(1);
      pre_d   = own_req;
    end else begin
      hold_d = hold_max ? hold_q : hold_q + HOLD_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= S_IDLE;
      enb_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      enb_q   <= enb_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      pre_q   <= pre_d;
    end

  assign ENB      = enb_q;
  assign GNT      = enb_q;
  assign PREEMPT  = pre_q;
  assign BUS_IDLE = state_q == S_IDLE;
endmodule

// File: doc/tribus_arb.md
TRIBUS_ARB -- requirements
Module: tribus_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of tristate drivers sharing one bus net, range 2..8.
REQ-002 SHALL have parameter TURN_CYC, default 1: dead cycles with all enables low between bus owners, range 1..7.
REQ-003 SHALL have parameter MAX_HOLD, default 16: maximum consecutive owned cycles while another requester waits, range 2..255.
REQ-004 SHALL have port CLK, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset; one clock, asynchronous, active-high.
REQ-006 SHALL have port REQ, input, N_REQ bits: per-driver bus request, level, held while ownership is wanted.
REQ-007 SHALL have port ENB, output, N_REQ bits: per-driver tristate enable, registered, at most one bit high.
REQ-008 SHALL have port GNT, output, N_REQ bits: per-requester grant, registered, identical to ENB.
REQ-009 SHALL have port BUS_IDLE, output, 1 bit: high when no driver is enabled and no turnaround is in progress.
REQ-010 SHALL have port PREEMPT, output, 1 bit: one-cycle pulse when ownership is revoked by the MAX_HOLD timeout.

Function
REQ-011 SHALL implement states IDLE, OWN and TURN.
REQ-012 In IDLE with REQ nonzero, SHALL pick the winner by round-robin and, at the next edge, enter OWN with ENB and GNT one-hot on the winner (one-cycle latency).
REQ-013 Round-robin SHALL search starting at index (last owner + 1) mod N_REQ, ascending with wrap-around; after reset the search starts at index 0.
REQ-014 In IDLE with REQ zero, SHALL stay in IDLE with ENB zero.
REQ-015 In OWN, SHALL hold ENB while REQ[owner] stays high, incrementing an 8-bit hold counter that saturates at MAX_HOLD.
REQ-016 In OWN, when REQ[owner] is low at an edge, SHALL clear ENB and GNT at that edge and enter TURN.
REQ-017 In OWN, when the hold counter equals MAX_HOLD and any other REQ bit is high, SHALL clear ENB, pulse PREEMPT for one cycle and enter TURN.
REQ-018 When release (REQ-016) and timeout (REQ-017) coincide, SHALL treat the event as release, with no PREEMPT.
REQ-019 When the hold counter reaches MAX_HOLD with no other requester, SHALL keep ownership and hold the counter at MAX_HOLD.
REQ-020 In TURN, SHALL keep ENB zero for exactly TURN_CYC cycles, then evaluate as IDLE in the same cycle the count expires.
REQ-021 A preempted owner whose REQ is still high SHALL rank last in the next arbitration.
REQ-022 REQ changes during TURN SHALL only affect the arbitration at TURN exit.
REQ-023 ENB SHALL never have two bits high, and SHALL never switch directly from one owner to another without at least TURN_CYC all-zero cycles.
REQ-024 BUS_IDLE SHALL be high only in IDLE.

Reset
REQ-025 When RST is high, SHALL asynchronously force IDLE, ENB=0, GNT=0, PREEMPT=0, BUS_IDLE=1, hold counter 0 and round-robin pointer to index 0.
REQ-026 When RST is asserted during OWN or TURN, SHALL drop ENB within the reset propagation, with no clock edge required.
REQ-027 After RST is released, SHALL make the first grant no earlier than the first rising CLK edge.

Structure
REQ-028 State enum, counter widths and parameter range constants SHALL reside in package tribus_arb_pkg.
REQ-029 The round-robin search SHALL be a combinational sub-module rr_pick (inputs: request vector and pointer; output: one-hot winner plus valid).
REQ-030 Total RTL SHALL be 120-400 lines, ENB flops included.

Verification
REQ-031 Scenario single requester: REQ=0001 from reset release -> ENB=0001 one edge later; REQ drops -> ENB=0000 next edge, BUS_IDLE=0 for 1 cycle, then BUS_IDLE=1.
REQ-032 Scenario all requesting, each holding 3 cycles: REQ=1111 -> owner order 0,1,2,3,0, each owner separated by exactly TURN_CYC zero cycles.
REQ-033 Scenario timeout (MAX_HOLD=4): REQ0 held, REQ2 raised -> ENB0 cleared after 4 owned cycles, PREEMPT pulses once, ENB=0100 after turnaround.
REQ-034 Scenario coincidence: REQ0 drops on the same edge the timeout fires -> no PREEMPT, normal TURN.
REQ-035 Scenario reset mid-OWN: assert RST between edges while ENB=0010 -> ENB=0000 immediately; after release with REQ=0010 -> ENB=0010 one edge later (pointer restarted at 0).
REQ-036 Assertions for the whole run: $onehot0(ENB); no cycle in which ENB changes from one nonzero value to a different nonzero value.
